// File: rtl/ex13_bool_axioms.sv
// ex13_bool_axioms
// Evaluates the four single-variable Boolean axioms on A (A+0, A.1, A+1, A.0)
// as pure combinational outputs. A small registered side-channel snapshots the
// axiom results, counts samples and ones, and latches a sticky error flag if a
// sampled result ever disagrees with the axiom it is supposed to demonstrate.
module ex13_bool_axioms #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    output logic             F1,
    output logic             F2,
    output logic             F3,
    output logic             F4,
    output logic [3:0]       F_q,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             axiom_err
);

    // Counter constants: increment step and the saturation ceiling.
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The F_q reset value is the axiom pattern for A=0: {F4,F3,F2,F1}.
    localparam logic [3:0] FQ_RST = 4'b0100;

    // Saturating increment: holds at the ceiling instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] value,
        input logic             en
    );
        logic [CNT_W-1:0] result;
        if (en && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic             w_f1;
    logic             w_f2;
    logic             w_f3;
    logic             w_f4;
    logic             w_violation;
    logic [CNT_W-1:0] w_sample_nxt;
    logic [CNT_W-1:0] w_ones_nxt;

    logic [3:0]       r_f_q;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_ones_cnt;
    logic             r_axiom_err;

    // The axioms themselves. Constants dominate in F3/F4, so they stay 1/0
    // even when A is X/Z; F1/F2 pass A (and any X) straight through.
    always_comb begin
        w_f1 = A | 1'b0;
        w_f2 = A & 1'b1;
        w_f3 = A | 1'b1;
        w_f4 = A & 1'b0;
    end

    // Consistency check of the current-cycle axiom values against A, plus the
    // next counter values.
    always_comb begin
        w_violation  = (w_f1 != A) | (w_f2 != A) | (w_f3 != 1'b1) | (w_f4 != 1'b0);
        w_sample_nxt = sat_inc(r_sample_cnt, 1'b1);
        w_ones_nxt   = sat_inc(r_ones_cnt, A);
    end

    // Side-channel registers: snapshot, saturating counters, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_q        <= FQ_RST;
            r_sample_cnt <= {CNT_W{1'b0}};
            r_ones_cnt   <= {CNT_W{1'b0}};
            r_axiom_err  <= 1'b0;
        end else begin
            r_f_q        <= {w_f4, w_f3, w_f2, w_f1};
            r_sample_cnt <= w_sample_nxt;
            r_ones_cnt   <= w_ones_nxt;
            r_axiom_err  <= r_axiom_err | w_violation;
        end
    end

    assign F1         = w_f1;
    assign F2         = w_f2;
    assign F3         = w_f3;
    assign F4         = w_f4;
    assign F_q        = r_f_q;
    assign sample_cnt = r_sample_cnt;
    assign ones_cnt   = r_ones_cnt;
    assign axiom_err  = r_axiom_err;

endmodule

// File: tb/tb_ex13_bool_axioms.sv
// Self-checking bench for ex13_bool_axioms: a vector table for the
// combinational axioms, then hand-written clocked sequences for reset,
// alternation, saturation and asynchronous mid-run reset.
module tb_ex13_bool_axioms;

    localparam int CNT_W = 8;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic             A;
    logic             F1, F2, F3, F4;
    logic [3:0]       F_q;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic             axiom_err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic a;
        logic f1;
        logic f2;
        logic f3;
        logic f4;
    } vec_t;

    vec_t vecs[4];

    ex13_bool_axioms #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .F1         (F1),
        .F2         (F2),
        .F3         (F3),
        .F4         (F4),
        .F_q        (F_q),
        .sample_cnt (sample_cnt),
        .ones_cnt   (ones_cnt),
        .axiom_err  (axiom_err)
    );

    // Clock generator, gated so the combinational checks run with no clock.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " F_q"},        {28'd0, F_q},        32'h4);
        chk({tag, " sample_cnt"}, {24'd0, sample_cnt}, 32'd0);
        chk({tag, " ones_cnt"},   {24'd0, ones_cnt},   32'd0);
        chk({tag, " axiom_err"},  {31'd0, axiom_err},  32'd0);
    endtask

    initial begin
        int comb_fail_before;
        n_checks = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        A        = 1'b0;
        rst_n    = 1'b1;

        vecs[0] = '{a: 1'b0, f1: 1'b0, f2: 1'b0, f3: 1'b1, f4: 1'b0};
        vecs[1] = '{a: 1'b1, f1: 1'b1, f2: 1'b1, f3: 1'b1, f4: 1'b0};
        vecs[2] = '{a: 1'b0, f1: 1'b0, f2: 1'b0, f3: 1'b1, f4: 1'b0};
        vecs[3] = '{a: 1'b1, f1: 1'b1, f2: 1'b1, f3: 1'b1, f4: 1'b0};

        // Asynchronous reset with no clock running at all.
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state("noclk_reset");

        // Combinational axioms, clock stopped.
        comb_fail_before = n_fail;
        for (int i = 0; i < 4; i++) begin
            A = vecs[i].a;
            #1;
            chk($sformatf("comb[%0d] F1", i), {31'd0, F1}, {31'd0, vecs[i].f1});
            chk($sformatf("comb[%0d] F2", i), {31'd0, F2}, {31'd0, vecs[i].f2});
            chk($sformatf("comb[%0d] F3", i), {31'd0, F3}, {31'd0, vecs[i].f3});
            chk($sformatf("comb[%0d] F4", i), {31'd0, F4}, {31'd0, vecs[i].f4});
        end
        if (n_fail == comb_fail_before) $display("Boolean axioms working");

        // Dominance holds even for an unknown operand.
        A = 1'bx;
        #1;
        chk("x F3", {31'd0, F3}, 32'd1);
        chk("x F4", {31'd0, F4}, 32'd0);

        // First clock after reset release with A=1.
        A      = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first F_q",        {28'd0, F_q},        32'h7);
        chk("first sample_cnt", {24'd0, sample_cnt}, 32'd1);
        chk("first ones_cnt",   {24'd0, ones_cnt},   32'd1);
        chk("first axiom_err",  {31'd0, axiom_err},  32'd0);

        // Reset between edges, then alternate A over 10 clocks.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state("alt_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            A = (i % 2 == 1) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            chk($sformatf("alt[%0d] F_q", i), {28'd0, F_q}, (i % 2 == 1) ? 32'h7 : 32'h4);
            chk($sformatf("alt[%0d] F1", i), {31'd0, F1}, {31'd0, A});
            @(negedge clk);
        end
        chk("alt sample_cnt", {24'd0, sample_cnt}, 32'd10);
        chk("alt ones_cnt",   {24'd0, ones_cnt},   32'd5);
        chk("alt axiom_err",  {31'd0, axiom_err},  32'd0);

        // Saturation: 300 clocks with A=1 after a fresh reset.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        A     = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (i == 100) begin
                chk("sat mid sample_cnt", {24'd0, sample_cnt}, 32'd100);
                chk("sat mid ones_cnt",   {24'd0, ones_cnt},   32'd100);
            end
            if (i == 255) begin
                chk("sat 255 sample_cnt", {24'd0, sample_cnt}, 32'd255);
            end
        end
        chk("sat sample_cnt", {24'd0, sample_cnt}, 32'd255);
        chk("sat ones_cnt",   {24'd0, ones_cnt},   32'd255);
        chk("sat axiom_err",  {31'd0, axiom_err},  32'd0);
        chk("sat F_q",        {28'd0, F_q},        32'h7);

        // Asynchronous reset mid-operation, while clk is high.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        chk("async F1 tracks A", {31'd0, F1}, 32'd1);
        chk("async F3",          {31'd0, F3}, 32'd1);
        A = 1'b0;
        #1;
        chk("async F2 tracks A", {31'd0, F2}, 32'd0);
        chk("async F4",          {31'd0, F4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post F_q",        {28'd0, F_q},        32'h4);
        chk("post sample_cnt", {24'd0, sample_cnt}, 32'd1);
        chk("post ones_cnt",   {24'd0, ones_cnt},   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex13_bool_axioms.md
Name: ex13_bool_axioms

Overview:
- Teaching/demo block that evaluates the four single-variable Boolean axioms on input A: A+0, A·1, A+1 and A·0.
- F1..F4 are purely combinational and independent of clock and reset. They stay valid when clk and rst_n are left unconnected.
- A small registered side-channel captures the axiom outputs, counts samples and raises a sticky error flag if any axiom result is ever inconsistent.
- Sits as a leaf in the digital-logic exercise set; the combinational outputs feed display/check logic directly.

Parameters:
- CNT_W, 8, width of the sample counter and of the ones counter (saturating).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  1  Boolean operand.
- F1  output  1  A OR 0 (identity for OR); equals A.
- F2  output  1  A AND 1 (identity for AND); equals A.
- F3  output  1  A OR 1 (dominance for OR); constant 1.
- F4  output  1  A AND 0 (dominance for AND); constant 0.
- F_q  output  4  registered {F4,F3,F2,F1}, captured each clk.
- sample_cnt  output  CNT_W  number of clocks sampled since reset, saturating.
- ones_cnt  output  CNT_W  number of sampled clocks with A=1, saturating.
- axiom_err  output  1  sticky flag: a registered sample violated an axiom.

Behaviour:
- Combinational path:
  - F1=A|1'b0, F2=A&1'b1, F3=A|1'b1, F4=A&1'b0.
  - Zero-cycle latency; outputs settle within the same delta/propagation time as A changes.
  - Must not depend on clk or rst_n. F3 is always 1 and F4 always 0, even when A is X/Z.
  - F1 and F2 follow A, so an X/Z on A yields X on F1 and F2.
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock): F_q=4'b0100, sample_cnt=0, ones_cnt=0, axiom_err=0.
  - F_q reset value is the A=0 axiom pattern: F4=0, F3=1, F2=0, F1=0.
- After reset release, each rising clk updates the registered outputs:
  - F_q <= {F4,F3,F2,F1}.
  - sample_cnt <= sample_cnt+1, saturating at 2^CNT_W-1 with no wrap.
  - ones_cnt <= ones_cnt+1 when A==1, saturating at 2^CNT_W-1 with no wrap.
  - axiom_err <= axiom_err | violation, where violation = (F1!=A)|(F2!=A)|(F3!=1)|(F4!=0), evaluated on the current-cycle values.
  - axiom_err stays sticky until reset.
- Reset asserted mid-operation clears every register immediately. The combinational outputs are unaffected by it.
- Registered outputs lag A by one clock.

Test Plan:
- Apply A=0 with no clock activity and wait 1 time unit -> F1=0, F2=0, F3=1, F4=0.
- Apply A=1 and wait 1 time unit -> F1=1, F2=1, F3=1, F4=0. A final "axioms working" pass is reported only if both checks pass.
- Hold rst_n=0, then release it and clock with A=1 -> the first rising edge gives F_q=4'b0111, sample_cnt=1, ones_cnt=1, axiom_err=0.
- Alternate A=0/1 for 10 clocks -> sample_cnt=10, ones_cnt=5, axiom_err=0. F_q toggles between 4'b0100 and 4'b0111, one clock behind A.
- With CNT_W=8, run 300 clocks with A=1 -> sample_cnt=255 and ones_cnt=255, both saturated.
- Assert rst_n low asynchronously between clock edges -> registers clear at once to F_q=4'b0100, counters 0, axiom_err 0, while F1..F4 keep tracking A.
